// File: rtl/board_init_pkg.sv
// Shared types and limits for the board-memory initialiser.
// Compile-time option BOARD_INIT_AUTOSTART_EN is consumed by board_init_ctrl.
package board_init_pkg;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } init_mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } init_state_e;

    localparam int MIN_READ_LAT = 1;

endpackage

// File: rtl/board_init_ctrl_if.sv
// Control, ROM-read and RAM-write signals of the board initialiser.
// The master modport is the initialiser; slave is the game FSM plus ROM/RAM side.
interface board_init_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
);
    logic              start;
    logic              mode;
    logic [DATA_W-1:0] fill_data;
    logic              abort;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;

    modport master (
        input  start, mode, fill_data, abort, rd_data,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        output start, mode, fill_data, abort, rd_data,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/init_delay_line.sv
// Valid + address shift register that lines RAM writes up with ROM read latency.
// A synchronous flush drops every in-flight valid; addresses are left as they are.
module init_delay_line #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_addr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_addr
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] addr [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr[i] <= '0;
            end
        end else begin
            vld[0]  <= in_valid && !flush;
            addr[0] <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i]  <= vld[i-1] && !flush;
                addr[i] <= addr[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_addr  = addr[DEPTH-1];

endmodule

// File: rtl/board_init_ctrl.sv
// Walks board RAM once per start, copying the level ROM or filling a constant.
// Define BOARD_INIT_AUTOSTART_EN to launch a COPY pass automatically after reset.
module board_init_ctrl
    import board_init_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 4,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    board_init_ctrl_if.master   bus
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int DCNT_W = $clog2(READ_LAT) + 1;
    localparam logic [CNT_W-1:0]  LAST_ADDR = CNT_W'(DEPTH - 1);
    localparam logic [DCNT_W-1:0] LAST_DRN  = DCNT_W'(READ_LAT - 1);

    if (READ_LAT < MIN_READ_LAT) begin : g_lat_check
        $error("board_init_ctrl: READ_LAT must be at least %0d", MIN_READ_LAT);
    end

    init_state_e       state;
    logic [CNT_W-1:0]  cnt;
    logic [DCNT_W-1:0] dcnt;
    init_mode_e        mode_q;
    logic [DATA_W-1:0] fill_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              busy_q;
    logic              done_q;

    logic              go;
    init_mode_e        go_mode;
    logic              flush;
    logic              dl_valid;
    logic [ADDR_W-1:0] dl_addr;

`ifdef BOARD_INIT_AUTOSTART_EN
    // Pending self-start; consumed by the first IDLE cycle after reset.
    logic auto_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            auto_q <= 1'b1;
        end else if (state == S_IDLE) begin
            auto_q <= 1'b0;
        end
    end

    assign go      = bus.start || auto_q;
    assign go_mode = auto_q ? MODE_COPY : init_mode_e'(bus.mode);
`else
    assign go      = bus.start;
    assign go_mode = init_mode_e'(bus.mode);
`endif

    assign flush = bus.abort && (state == S_RUN || state == S_DRAIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            dcnt      <= '0;
            mode_q    <= MODE_COPY;
            fill_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (go) begin
                        state     <= S_RUN;
                        cnt       <= '0;
                        mode_q    <= go_mode;
                        fill_q    <= bus.fill_data;
                        rd_en_q   <= (go_mode == MODE_COPY);
                        rd_addr_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        state     <= S_IDLE;
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                        busy_q    <= 1'b0;
                    end else if (cnt == LAST_ADDR) begin
                        state     <= S_DRAIN;
                        dcnt      <= '0;
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        rd_addr_q <= ADDR_W'(cnt + 1'b1);
                    end
                end
                // Wait out the ROM latency so the last write lands before done.
                S_DRAIN: begin
                    if (bus.abort) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else if (dcnt == LAST_DRN) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    init_delay_line #(
        .WIDTH (ADDR_W),
        .DEPTH (READ_LAT)
    ) u_delay (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (state == S_RUN),
        .in_addr   (ADDR_W'(cnt)),
        .out_valid (dl_valid),
        .out_addr  (dl_addr)
    );

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.wr_en   = dl_valid;
    assign bus.wr_addr = dl_addr;
    assign bus.wr_data = !dl_valid ? '0 :
                         (mode_q == MODE_COPY) ? bus.rd_data : fill_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: doc/board_init_ctrl.md
# board_init_ctrl

Parametrised board-memory initialiser: on a start request it walks every address of the board RAM once, either copying the level ROM into it (COPY mode) or filling it with a constant (FILL mode), at one word per clock behind a configurable ROM read latency. It sits between the game FSM and the board RAM/ROM pair. `busy` freezes gameplay logic while it runs, and `done` reports completion.

## Interface
- `ADDR_W`, 10, address width of board RAM and ROM
- `DATA_W`, 4, tile code width
- `DEPTH`, 1024, number of words initialised (addresses 0..DEPTH-1); 1 ≤ DEPTH ≤ 2^ADDR_W
- `READ_LAT`, 1, ROM read latency in cycles; must be ≥ 1
- `clk`  input  1  system clock, rising-edge
- `reset`  input  1  asynchronous, active-low reset (0 = reset)
- `start`  input  1  request pulse; accepted only in IDLE
- `mode`  input  1  0 = COPY, 1 = FILL; sampled with accepted `start`
- `fill_data`  input  DATA_W  constant for FILL; sampled with accepted `start`
- `abort`  input  1  cancel the running pass
- `rd_en`  output  1  ROM read strobe
- `rd_addr`  output  ADDR_W  ROM read address
- `rd_data`  input  DATA_W  ROM data, valid READ_LAT cycles after `rd_en`
- `wr_en`  output  1  RAM write strobe
- `wr_addr`  output  ADDR_W  RAM write address
- `wr_data`  output  DATA_W  RAM write data
- `busy`  output  1  high in RUN and DRAIN
- `done`  output  1  one-cycle completion pulse

## Operation
- States:
  - IDLE → RUN when `start` is high.
  - RUN → DRAIN after the read for DEPTH-1 is issued.
  - DRAIN → DONE after READ_LAT cycles.
  - DONE → IDLE unconditionally.
- RUN: one address per cycle, 0 upward. COPY asserts `rd_en` with `rd_addr` equal to the counter. FILL keeps `rd_en` = 0 but follows the identical schedule.
- Write pipeline: a READ_LAT-deep delay line carries a valid bit and the address. `wr_en` equals the delayed valid and `wr_addr` equals the delayed address. `wr_data` is `rd_data` in COPY and the registered `fill_data` in FILL.
- `start` is ignored outside IDLE. `mode` and `fill_data` are ignored except in the accepting cycle.
- `abort` in RUN or DRAIN moves the block to IDLE on the next edge and flushes all delay-line valids, so no further `wr_en` is issued and no `done` pulse follows. Writes already issued stand. `abort` is ignored in IDLE and DONE.
- `abort` and `start` high together in IDLE: `start` wins.
- Address counter is $clog2(DEPTH)+1 bits wide, zero-extended/truncated to ADDR_W on output. It never wraps and stops at DEPTH-1.
- Reset asserted (`reset` = 0): state IDLE, counter 0, delay line cleared. All outputs are 0 (`rd_en`, `rd_addr`, `wr_en`, `wr_addr`, `wr_data`, `busy`, `done`). Reset mid-pass abandons the pass with no `done`.

## Timing
- `start` sampled at edge 0; RUN occupies cycles 1..DEPTH, with the read for address i in cycle i+1.
- Write for address i in cycle i+1+READ_LAT; last write in cycle DEPTH+READ_LAT.
- `done` high in cycle DEPTH+READ_LAT+1; `busy` high in cycles 1..DEPTH+READ_LAT.
- Earliest next accepted `start`: edge DEPTH+READ_LAT+2.
- Throughput: one word per cycle, no bubbles.

## Configuration
- `BOARD_INIT_AUTOSTART_EN` defined: on reset release the block behaves as if `start` = 1 with `mode` = COPY were presented in the first IDLE cycle, so the board is loaded without an external request.
- Macro absent: the block idles after reset until an explicit `start`.

## Structure
- Package `board_init_pkg` holds:
  - `init_mode_e` (MODE_COPY, MODE_FILL)
  - `init_state_e` (S_IDLE, S_RUN, S_DRAIN, S_DONE)
  - `MIN_READ_LAT` = 1, plus an elaboration check that READ_LAT ≥ MIN_READ_LAT
- One sub-module, `init_delay_line`: parameterised by width and depth, a valid+address shift register with synchronous flush and async active-low reset.

## Test plan
- COPY, DEPTH=8, READ_LAT=1, ROM[i]=i+3 → RAM[0..7]=3..10; `busy` high for 9 cycles; `done` pulse at cycle 10; no write outside 0..7.
- FILL, `fill_data`=4'hA, DEPTH=8, READ_LAT=3 → eight writes of 4'hA in cycles 4..11; `rd_en` never high; `done` at cycle 12.
- `start` re-pulsed during RUN with `mode`=FILL → ignored; pass completes as COPY with the original data.
- `abort` in cycle 5 of COPY, DEPTH=8, READ_LAT=2 → no `wr_en` from cycle 6 onward; no `done`; `busy` low at cycle 6; a new `start` is then accepted.
- `reset` driven low mid-DRAIN → all outputs 0 immediately (asynchronously); after release the block is in IDLE. With `BOARD_INIT_AUTOSTART_EN`, a full COPY pass runs automatically instead.
- Back-to-back: second `start` at edge DEPTH+READ_LAT+2 → accepted, second pass timing identical to the first.
